// File: rtl/kv_store_pkg.sv
// rtl/kv_store_pkg.sv - shared state/op encodings and TTL constant helper for kv_store_responder
package kv_store_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_UPDATE,
    ST_RESPOND
  } state_e;

  typedef enum logic [1:0] {
    OP_GET,
    OP_SET,
    OP_DEL,
    OP_EXPIRE
  } op_e;

  localparam int TTL_MAX_WIDTH = 64;

  // All-ones TTL of the given width marks an entry that never ages.
  function automatic logic [TTL_MAX_WIDTH-1:0] ttl_persist(input int width);
    ttl_persist = '0;
    for (int i = 0; i < TTL_MAX_WIDTH; i++) begin
      if (i < width) ttl_persist[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/kv_ttl_ticker.sv
// rtl/kv_ttl_ticker.sv - TICK_DIV prescaler emitting a single-cycle TTL tick
module kv_ttl_ticker #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/kv_store_responder.sv
// rtl/kv_store_responder.sv - fully associative key/value/TTL responder; KV_TTL_EXPIRY_EN enables TTL ageing
module kv_store_responder
  import kv_store_pkg::*;
#(
  parameter int KEY_WIDTH   = 64,
  parameter int VALUE_WIDTH = 64,
  parameter int TTL_WIDTH   = 32,
  parameter int ENTRIES     = 8,
  parameter int TICK_DIV    = 1000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mem_cmd_valid,
  input  logic                           mem_cmd_write,
  input  logic [KEY_WIDTH-1:0]           mem_cmd_key,
  input  logic [VALUE_WIDTH-1:0]         mem_cmd_value,
  input  logic [TTL_WIDTH-1:0]           mem_cmd_ttl,
  output logic                           mem_cmd_ready,
  output logic                           mem_resp_valid,
  output logic                           mem_resp_hit,
  output logic [VALUE_WIDTH-1:0]         mem_resp_value,
  output logic [TTL_WIDTH-1:0]           mem_resp_ttl,
  input  logic                           mem_resp_ready,
  output logic [$clog2(ENTRIES+1)-1:0]   entry_count
);

  localparam int IW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(ENTRIES - 1);
  localparam logic [TTL_WIDTH-1:0] TTL_PERSIST = TTL_WIDTH'(ttl_persist(TTL_WIDTH));

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic [KEY_WIDTH-1:0]    cmd_key_q, cmd_key_d;
  logic [VALUE_WIDTH-1:0]  cmd_value_q, cmd_value_d;
  logic [TTL_WIDTH-1:0]    cmd_ttl_q, cmd_ttl_d;
  logic [IW-1:0]           idx_q, idx_d, match_idx_q, match_idx_d, free_idx_q, free_idx_d;
  logic                    match_q, match_d, free_q, free_d;
  logic                    ready_q, ready_d, resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d;
  logic [VALUE_WIDTH-1:0]  resp_value_q, resp_value_d;
  logic [TTL_WIDTH-1:0]    resp_ttl_q, resp_ttl_d;
  logic [CW-1:0]           count_q, count_d;

  logic [ENTRIES-1:0]      tbl_valid_q;
  logic [KEY_WIDTH-1:0]    tbl_key_q   [ENTRIES];
  logic [VALUE_WIDTH-1:0]  tbl_value_q [ENTRIES];
  logic [TTL_WIDTH-1:0]    tbl_ttl_q   [ENTRIES];

  logic                    wr_en, wr_valid;
  logic [IW-1:0]           wr_idx;
  logic [KEY_WIDTH-1:0]    wr_key;
  logic [VALUE_WIDTH-1:0]  wr_value;
  logic [TTL_WIDTH-1:0]    wr_ttl;
  logic                    tick, scan_live, match_live;

`ifdef KV_TTL_EXPIRY_EN
  kv_ttl_ticker #(.TICK_DIV(TICK_DIV)) u_ticker (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );
`else
  // TTLs never age in this build; TICK_DIV >= 1 keeps this constant low.
  assign tick = (TICK_DIV == 0);
`endif

  assign mem_cmd_ready  = ready_q;
  assign mem_resp_valid = resp_valid_q;
  assign mem_resp_hit   = resp_hit_q;
  assign mem_resp_value = resp_value_q;
  assign mem_resp_ttl   = resp_ttl_q;
  assign entry_count    = count_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cmd_key_d    = cmd_key_q;
    cmd_value_d  = cmd_value_q;
    cmd_ttl_d    = cmd_ttl_q;
    idx_d        = idx_q;
    match_d      = match_q;
    match_idx_d  = match_idx_q;
    free_d       = free_q;
    free_idx_d   = free_idx_q;
    ready_d      = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_hit_d   = resp_hit_q;
    resp_value_d = resp_value_q;
    resp_ttl_d   = resp_ttl_q;
    wr_en        = 1'b0;
    wr_valid     = 1'b1;
    wr_idx       = match_idx_q;
    wr_key       = cmd_key_q;
    wr_value     = cmd_value_q;
    wr_ttl       = cmd_ttl_q;
    scan_live    = tbl_valid_q[idx_q] && (tbl_ttl_q[idx_q] != '0);
    // A match may have aged out after it was scanned, so liveness is re-checked here.
    match_live   = match_q && tbl_valid_q[match_idx_q] && (tbl_ttl_q[match_idx_q] != '0);

    case (state_q)
      ST_IDLE: begin
        ready_d = mem_cmd_valid && !ready_q;
        if (mem_cmd_valid && ready_q) begin
          cmd_key_d   = mem_cmd_key;
          cmd_value_d = mem_cmd_value;
          cmd_ttl_d   = mem_cmd_ttl;
          if (!mem_cmd_write)          op_d = OP_GET;
          else if (mem_cmd_ttl == '0)  op_d = OP_DEL;
          else if (mem_cmd_value == '0) op_d = OP_EXPIRE;
          else                         op_d = OP_SET;
          idx_d   = '0;
          match_d = 1'b0;
          free_d  = 1'b0;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (scan_live && !match_q && (tbl_key_q[idx_q] == cmd_key_q)) begin
          match_d     = 1'b1;
          match_idx_d = idx_q;
        end
        if (!scan_live && !free_q) begin
          free_d     = 1'b1;
          free_idx_d = idx_q;
        end
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        state_d      = ST_RESPOND;
        resp_valid_d = 1'b1;
        resp_hit_d   = 1'b0;
        resp_value_d = '0;
        resp_ttl_d   = '0;
        case (op_q)
          OP_GET: if (match_live) begin
            resp_hit_d   = 1'b1;
            resp_value_d = tbl_value_q[match_idx_q];
            resp_ttl_d   = tbl_ttl_q[match_idx_q];
          end
          OP_DEL: if (match_live) begin
            wr_en        = 1'b1;
            wr_valid     = 1'b0;
            wr_value     = tbl_value_q[match_idx_q];
            wr_ttl       = tbl_ttl_q[match_idx_q];
            resp_hit_d   = 1'b1;
            resp_value_d = tbl_value_q[match_idx_q];
            resp_ttl_d   = tbl_ttl_q[match_idx_q];
          end
          OP_EXPIRE: if (match_live) begin
            wr_en        = 1'b1;
            wr_value     = tbl_value_q[match_idx_q];
            resp_hit_d   = 1'b1;
            resp_value_d = tbl_value_q[match_idx_q];
            resp_ttl_d   = cmd_ttl_q;
          end
          default: if (match_live || free_q) begin
            wr_en        = 1'b1;
            wr_idx       = match_live ? match_idx_q : free_idx_q;
            resp_hit_d   = 1'b1;
            resp_value_d = cmd_value_q;
            resp_ttl_d   = cmd_ttl_q;
          end
        endcase
      end
      ST_RESPOND: begin
        if (mem_resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < ENTRIES; i++) count_d = count_d + CW'(tbl_valid_q[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_GET;
      cmd_key_q    <= '0;
      cmd_value_q  <= '0;
      cmd_ttl_q    <= '0;
      idx_q        <= '0;
      match_q      <= 1'b0;
      match_idx_q  <= '0;
      free_q       <= 1'b0;
      free_idx_q   <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_value_q <= '0;
      resp_ttl_q   <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cmd_key_q    <= cmd_key_d;
      cmd_value_q  <= cmd_value_d;
      cmd_ttl_q    <= cmd_ttl_d;
      idx_q        <= idx_d;
      match_q      <= match_d;
      match_idx_q  <= match_idx_d;
      free_q       <= free_d;
      free_idx_q   <= free_idx_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_value_q <= resp_value_d;
      resp_ttl_q   <= resp_ttl_d;
      count_q      <= count_d;
    end
  end

  // The UPDATE write takes precedence over the tick decrement on the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_key_q[i]   <= '0;
        tbl_value_q[i] <= '0;
        tbl_ttl_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (wr_en && (wr_idx == IW'(i))) begin
          tbl_valid_q[i] <= wr_valid;
          tbl_key_q[i]   <= wr_key;
          tbl_value_q[i] <= wr_value;
          tbl_ttl_q[i]   <= wr_ttl;
        end else if (tick && tbl_valid_q[i] && (tbl_ttl_q[i] != '0) &&
                     (tbl_ttl_q[i] != TTL_PERSIST)) begin
          tbl_ttl_q[i] <= tbl_ttl_q[i] - 1'b1;
          if (tbl_ttl_q[i] == TTL_WIDTH'(1)) tbl_valid_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_kv_store_responder.sv
// tb/tb_kv_store_responder.sv - scoreboard bench for kv_store_responder against a key-indexed reference model
`timescale 1ns/1ps
module tb_kv_store_responder;

  localparam int KW = 64, VW = 64, TW = 32, ENT = 8, TDIV = 4;
  localparam int CNTW = $clog2(ENT + 1);
  localparam logic [TW-1:0] TTL_ALL = '1;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            mem_cmd_valid = 1'b0, mem_cmd_write = 1'b0, mem_resp_ready = 1'b0;
  logic [KW-1:0]   mem_cmd_key = '0;
  logic [VW-1:0]   mem_cmd_value = '0;
  logic [TW-1:0]   mem_cmd_ttl = '0;
  logic            mem_cmd_ready, mem_resp_valid, mem_resp_hit;
  logic [VW-1:0]   mem_resp_value;
  logic [TW-1:0]   mem_resp_ttl;
  logic [CNTW-1:0] entry_count;

  always #5 clk = ~clk;

  kv_store_responder #(
    .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TTL_WIDTH(TW), .ENTRIES(ENT), .TICK_DIV(TDIV)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_write(mem_cmd_write),
    .mem_cmd_key(mem_cmd_key), .mem_cmd_value(mem_cmd_value), .mem_cmd_ttl(mem_cmd_ttl),
    .mem_cmd_ready(mem_cmd_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_hit(mem_resp_hit),
    .mem_resp_value(mem_resp_value), .mem_resp_ttl(mem_resp_ttl),
    .mem_resp_ready(mem_resp_ready), .entry_count(entry_count)
  );

  int n_total = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a capacity-limited map key -> (value, ttl).
  logic [VW-1:0] m_val [logic [KW-1:0]];
  logic [TW-1:0] m_ttl [logic [KW-1:0]];

  typedef struct {
    logic          hit;
    logic [VW-1:0] value;
    logic [TW-1:0] ttl;
    longint        cyc;
  } exp_t;
  exp_t exp_q[$];

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            presc = 0, pcnt = 0;
  bit            pend = 0, outstanding = 0;
  logic          cap_write;
  logic [KW-1:0] cap_key;
  logic [VW-1:0] cap_val;
  logic [TW-1:0] cap_ttl;

  // Evaluated at each falling edge: predicts what the next rising edge does.
  always @(negedge clk) begin : model
    bit            tick, upd;
    logic [KW-1:0] uk;
    exp_t          e;
    logic [KW-1:0] dead[$];
    if (!rst_n) begin
      m_val.delete(); m_ttl.delete(); exp_q.delete();
      presc = 0; pcnt = 0; pend = 0; outstanding = 0;
    end else begin
      tick = 0; upd = 0; uk = '0;
`ifdef KV_TTL_EXPIRY_EN
      tick  = (presc == TDIV - 1);
      presc = tick ? 0 : presc + 1;
`endif
      if (mem_cmd_ready) check("cmd_ready_only_idle", {63'd0, pend || outstanding}, 64'd0);
      if (pend) begin
        if (pcnt == 0) begin
          pend = 0; outstanding = 1;
          e.hit = 1'b0; e.value = '0; e.ttl = '0; e.cyc = cyc + 1;
          if (!cap_write) begin
            if (m_val.exists(cap_key)) begin
              e.hit = 1'b1; e.value = m_val[cap_key]; e.ttl = m_ttl[cap_key];
            end
          end else if (cap_ttl == '0) begin
            if (m_val.exists(cap_key)) begin
              e.hit = 1'b1; e.value = m_val[cap_key]; e.ttl = m_ttl[cap_key];
              m_val.delete(cap_key); m_ttl.delete(cap_key);
            end
          end else if (cap_val == '0) begin
            if (m_val.exists(cap_key)) begin
              m_ttl[cap_key] = cap_ttl;
              e.hit = 1'b1; e.value = m_val[cap_key]; e.ttl = cap_ttl;
              upd = 1; uk = cap_key;
            end
          end else if (m_val.exists(cap_key) || m_val.num() < ENT) begin
            m_val[cap_key] = cap_val; m_ttl[cap_key] = cap_ttl;
            e.hit = 1'b1; e.value = cap_val; e.ttl = cap_ttl;
            upd = 1; uk = cap_key;
          end
          exp_q.push_back(e);
        end else begin
          pcnt--;
        end
      end
      if (mem_cmd_valid && mem_cmd_ready) begin
        pend = 1; pcnt = ENT;
        cap_write = mem_cmd_write; cap_key = mem_cmd_key;
        cap_val = mem_cmd_value; cap_ttl = mem_cmd_ttl;
      end
      if (mem_resp_valid && mem_resp_ready) outstanding = 0;
      if (tick) begin
        dead.delete();
        foreach (m_ttl[k]) begin
          if (!(upd && k == uk) && m_ttl[k] != TTL_ALL) begin
            m_ttl[k] = m_ttl[k] - 1;
            if (m_ttl[k] == '0) dead.push_back(k);
          end
        end
        foreach (dead[i]) begin
          m_val.delete(dead[i]); m_ttl.delete(dead[i]);
        end
      end
    end
  end

  bit            seen = 0;
  logic          h_hit;
  logic [VW-1:0] h_val;
  logic [TW-1:0] h_ttl;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      seen = 0;
    end else if (mem_resp_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_response", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_hit", {63'd0, mem_resp_hit}, {63'd0, e.hit});
          check("resp_value", mem_resp_value, e.value);
          check("resp_ttl", {32'd0, mem_resp_ttl}, {32'd0, e.ttl});
          check("resp_latency", cyc, e.cyc);
        end
        h_hit = mem_resp_hit; h_val = mem_resp_value; h_ttl = mem_resp_ttl;
        seen = 1;
      end else begin
        check("resp_stable",
              {63'd0, (mem_resp_hit !== h_hit) || (mem_resp_value !== h_val) || (mem_resp_ttl !== h_ttl)},
              64'd0);
      end
      if (mem_resp_ready) seen = 0;
    end
  end

  task automatic send(input logic wr, input logic [KW-1:0] k, input logic [VW-1:0] v,
                      input logic [TW-1:0] t);
    int n;
    n = 0;
    @(posedge clk); #1;
    mem_cmd_valid = 1'b1; mem_cmd_write = wr; mem_cmd_key = k;
    mem_cmd_value = v; mem_cmd_ttl = t;
    @(negedge clk);
    while (!mem_cmd_ready && n < 20) begin
      @(negedge clk); n++;
    end
    check("cmd_ready_seen", {63'd0, mem_cmd_ready}, 64'd1);
    @(posedge clk); #1;
    mem_cmd_valid = 1'b0;
  endtask

  task automatic finish_resp(input int hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!mem_resp_valid && n < 40) begin
      @(negedge clk); n++;
    end
    check("resp_valid_seen", {63'd0, mem_resp_valid}, 64'd1);
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 mem_resp_ready = 1'b1;
    @(posedge clk); #1 mem_resp_ready = 1'b0;
    @(negedge clk);
    check("resp_valid_dropped", {63'd0, mem_resp_valid}, 64'd0);
  endtask

  task automatic cmd(input logic wr, input logic [KW-1:0] k, input logic [VW-1:0] v,
                     input logic [TW-1:0] t, input int hold);
    send(wr, k, v, t);
    finish_resp(hold);
  endtask

  task automatic check_count(input string name);
    repeat (2) @(posedge clk);
    #2;
    check(name, {{(64-CNTW){1'b0}}, entry_count}, 64'(m_val.num()));
  endtask

  initial begin
    int            op, hold, quiet_resp;
    logic [KW-1:0] k;
    logic [VW-1:0] v;
    logic [TW-1:0] t;

    @(negedge clk);
    check("rst_cmd_ready", {63'd0, mem_cmd_ready}, 64'd0);
    check("rst_resp_valid", {63'd0, mem_resp_valid}, 64'd0);
    check("rst_resp_hit", {63'd0, mem_resp_hit}, 64'd0);
    check("rst_resp_value", mem_resp_value, 64'd0);
    check("rst_resp_ttl", {32'd0, mem_resp_ttl}, 64'd0);
    check("rst_entry_count", {{(64-CNTW){1'b0}}, entry_count}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    cmd(1'b1, 64'h11, 64'hAA, 32'h100, 0);
    check_count("count_after_set");
    cmd(1'b0, 64'h11, 64'h0, 32'h0, 5);
    cmd(1'b1, 64'h11, 64'h0, 32'h5, 0);
    cmd(1'b1, 64'h11, 64'h0, 32'h0, 0);
    check_count("count_after_delete");
    cmd(1'b0, 64'h11, 64'h0, 32'h0, 1);

    for (int i = 0; i < ENT; i++) cmd(1'b1, 64'h200 + 64'(i), 64'hB000 + 64'(i), 32'h20000 + 32'(i), 0);
    cmd(1'b1, 64'h2FF, 64'hDEAD, 32'h20000, 0);
    check_count("count_full");
    cmd(1'b1, 64'h203, 64'hBEEF, 32'h30000, 0);

    for (int i = 0; i < 60; i++) begin
      op   = $urandom_range(0, 3);
      hold = $urandom_range(0, 3);
      k    = 64'h200 + 64'($urandom_range(0, 11));
      v    = {$urandom, $urandom} | 64'd1;
      t    = ($urandom_range(0, 3) == 0) ? TTL_ALL : 32'h1000 + 32'($urandom_range(0, 16'hFFFF));
      case (op)
        0:       cmd(1'b0, k, '0, '0, hold);
        1:       cmd(1'b1, k, v, t, hold);
        2:       cmd(1'b1, k, v, '0, hold);
        default: cmd(1'b1, k, '0, t, hold);
      endcase
      if (i % 10 == 9) check_count("count_random");
    end

    send(1'b1, 64'h2AA, 64'h77, 32'h100);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_resp_valid", {63'd0, mem_resp_valid}, 64'd0);
    check("midrst_entry_count", {{(64-CNTW){1'b0}}, entry_count}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmd(1'b0, 64'h201, '0, '0, 0);

    cmd(1'b1, 64'h300, 64'h55, 32'h2, 0);
    repeat (20) @(posedge clk);
    check_count("count_after_expiry");
    cmd(1'b0, 64'h300, '0, '0, 0);
    cmd(1'b1, 64'h301, 64'h66, TTL_ALL, 0);
    repeat (40) @(posedge clk);
    cmd(1'b0, 64'h301, '0, '0, 0);
    cmd(1'b1, 64'h302, 64'h99, 32'h40, 0);
    cmd(1'b0, 64'h302, '0, '0, 2);
    check_count("count_end");

    @(posedge clk); #1;
    mem_cmd_valid = 1'b1; mem_cmd_write = 1'b0; mem_cmd_key = 64'h301;
    @(posedge clk); #1;
    mem_cmd_valid = 1'b0;
    @(negedge clk);
    check("ready_pulse_no_capture", {63'd0, mem_cmd_ready}, 64'd1);
    quiet_resp = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_resp_valid) quiet_resp++;
    end
    check("no_resp_without_capture", 64'(quiet_resp), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
